// File: rtl/input_event_conditioner_if.sv
// rtl/input_event_conditioner_if.sv - pin-side inputs and conditioned event outputs
interface input_event_conditioner_if #(
  parameter int N_CH = 3
);
  logic [N_CH-1:0] in_raw;
  logic [N_CH-1:0] en_mask;
  logic [N_CH-1:0] clr;
  logic [N_CH-1:0] level_o;
  logic [N_CH-1:0] rise_o;
  logic [N_CH-1:0] fall_o;
  logic [N_CH-1:0] pending_o;
  logic            irq_o;

  modport master (
    output in_raw, en_mask, clr,
    input  level_o, rise_o, fall_o, pending_o, irq_o
  );

  modport slave (
    input  in_raw, en_mask, clr,
    output level_o, rise_o, fall_o, pending_o, irq_o
  );
endinterface

// File: rtl/input_event_conditioner.sv
// rtl/input_event_conditioner.sv - per-channel sync, polarity fix, debounce, edge pulses, sticky pending, masked irq
module input_event_conditioner #(
  parameter int              N_CH            = 3,
  parameter int              SYNC_STAGES     = 2,
  parameter int              DEBOUNCE_CYCLES = 4,
  parameter logic [N_CH-1:0] ACTIVE_LOW      = {N_CH{1'b1}},
  parameter int              PEND_MODE       = 0
) (
  input  logic                        clk,
  input  logic                        arst,
  input_event_conditioner_if.slave    bus
);
  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s;
  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] rise_q, rise_d;
  logic [N_CH-1:0] fall_q, fall_d;
  logic [N_CH-1:0] pend_q, pend_d;
  logic [N_CH-1:0] set_ev;

  // Sync flops reset to the idle pin level so leaving reset never looks like an edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= ACTIVE_LOW;
    end else begin
      sync_q[0] <= bus.in_raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

  always_comb begin
    case (PEND_MODE)
      0:       set_ev = rise_q;
      1:       set_ev = fall_q;
      default: set_ev = rise_q | fall_q;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (s[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = s[i];
        rise_d[i]  = s[i];
        fall_d[i]  = ~s[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    // A set arriving with a clear on the same edge wins, so no event is lost.
    pend_d = (pend_q & ~bus.clr) | set_ev;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
    end
  end

  assign bus.level_o   = level_q;
  assign bus.rise_o    = rise_q;
  assign bus.fall_o    = fall_q;
  assign bus.pending_o = pend_q;
  assign bus.irq_o     = |(pend_q & bus.en_mask);
endmodule

// File: tb/tb_input_event_conditioner.sv
// tb/tb_input_event_conditioner.sv - vector table, corner sequences and randomized model check
module tb_input_event_conditioner;
  localparam int         N   = 3;
  localparam int         SYN = 2;
  localparam int         DEB = 4;
  localparam logic [2:0] AL  = 3'b011;

  logic clk  = 1'b0;
  logic arst = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  input_event_conditioner_if #(.N_CH(N)) bus ();

  input_event_conditioner #(
    .N_CH(N), .SYNC_STAGES(SYN), .DEBOUNCE_CYCLES(DEB), .ACTIVE_LOW(AL), .PEND_MODE(0)
  ) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [12:0] dut_all;
  assign dut_all = {bus.level_o, bus.rise_o, bus.fall_o, bus.pending_o, bus.irq_o};

  typedef struct {
    logic [2:0] raw, en, clr;
    logic [2:0] lvl, rise, fall, pend;
    logic       irq;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [2:0] raw, en, clr, lvl, rise, fall, pend, input logic irq);
    vec_t v;
    v.raw = raw; v.en = en; v.clr = clr;
    v.lvl = lvl; v.rise = rise; v.fall = fall; v.pend = pend; v.irq = irq;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Reference model: the pin value seen by the filter is the one sampled SYN edges
  // earlier; a level flips once the last DEB seen samples all disagree with it.
  logic [2:0] pipe[$];
  logic [2:0] win[$];
  logic [2:0] m_level, m_rise, m_fall, m_pend;

  task automatic model_reset();
    pipe.delete();
    win.delete();
    for (int k = 0; k < SYN; k++) pipe.push_back(3'b000);
    m_level = '0; m_rise = '0; m_fall = '0; m_pend = '0;
  endtask

  task automatic model_edge(input logic [2:0] raw, input logic [2:0] clr);
    logic [2:0] seen;
    bit all_diff;
    seen = pipe.pop_front();
    pipe.push_back(raw ^ AL);
    win.push_back(seen);
    if (win.size() > DEB) void'(win.pop_front());
    m_pend = (m_pend & ~clr) | m_rise;
    m_rise = '0;
    m_fall = '0;
    for (int c = 0; c < N; c++) begin
      all_diff = (win.size() == DEB);
      foreach (win[k]) if (win[k][c] == m_level[c]) all_diff = 0;
      if (all_diff) begin
        m_level[c] = ~m_level[c];
        if (m_level[c]) m_rise[c] = 1'b1;
        else            m_fall[c] = 1'b1;
      end
    end
  endtask

  initial begin
    logic [2:0] r, c, e;
    bus.in_raw = 3'b011; bus.en_mask = '0; bus.clr = '0;

    // Reset state, then idle with no pulses
    #1 arst = 1'b1;
    @(negedge clk);
    check("reset_outputs", 32'(dut_all), 32'(0));
    arst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      check("idle_after_reset", 32'(dut_all), 32'(0));
    end

    // Latency (8), glitch of 3 cycles (9), accepted 4-cycle pulse (11)
    for (int k = 0; k < 5; k++) add_vec(3'b010, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 0);
    add_vec(3'b010, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000, 3'b000, 0);
    add_vec(3'b010, 3'b001, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 1);
    add_vec(3'b010, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 0);
    for (int k = 0; k < 3; k++) add_vec(3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 0);
    for (int k = 0; k < 6; k++) add_vec(3'b010, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 0);
    for (int k = 0; k < 4; k++) add_vec(3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 0);
    add_vec(3'b010, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 0);
    add_vec(3'b010, 3'b000, 3'b000, 3'b011, 3'b010, 3'b000, 3'b001, 0);
    add_vec(3'b010, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 3'b011, 0);
    add_vec(3'b010, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 3'b011, 0);
    add_vec(3'b010, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 3'b011, 0);
    add_vec(3'b010, 3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b011, 0);
    add_vec(3'b010, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000, 3'b011, 1);

    foreach (vecs[i]) begin
      bus.in_raw = vecs[i].raw; bus.en_mask = vecs[i].en; bus.clr = vecs[i].clr;
      step(1);
      check($sformatf("vec%0d", i), 32'(dut_all),
            32'({vecs[i].lvl, vecs[i].rise, vecs[i].fall, vecs[i].pend, vecs[i].irq}));
    end

    // Set/clear race on channel 0
    bus.clr = 3'b111; step(1); bus.clr = '0;
    check("clr_all", 32'({bus.pending_o, bus.irq_o}), 32'(0));
    bus.in_raw = 3'b011; step(10);
    check("ch0_released", 32'({bus.level_o, bus.pending_o}), 32'(0));
    bus.in_raw = 3'b010;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("no_early_rise", 32'(bus.rise_o), 32'(0));
    end
    step(1);
    check("rise_at_edge6", 32'(bus.rise_o), 32'(3'b001));
    bus.clr = 3'b001; step(1);
    check("set_beats_clr", 32'(bus.pending_o), 32'(3'b001));
    step(1);
    check("clr_second", 32'(bus.pending_o), 32'(3'b000));
    bus.clr = '0;

    // Masking with simultaneous events on channels 0 and 2
    bus.in_raw = 3'b011; step(10);
    bus.in_raw = 3'b110; step(10);
    bus.en_mask = 3'b010; #1;
    check("masked_pend_irq", 32'({bus.pending_o, bus.irq_o}), 32'({3'b101, 1'b0}));
    bus.en_mask = 3'b100; #1;
    check("unmask_irq_same_cycle", 32'(bus.irq_o), 32'(1));
    bus.clr = 3'b100; step(1); bus.clr = '0;
    check("clr_drops_irq", 32'({bus.pending_o, bus.irq_o}), 32'({3'b001, 1'b0}));

    // Reset in the middle of a debounce count
    bus.in_raw = 3'b010; step(10);
    check("ch2_low", 32'(bus.level_o), 32'(3'b001));
    bus.in_raw = 3'b110; step(4);
    arst = 1'b1; #1;
    check("async_reset_now", 32'(dut_all), 32'(0));
    step(1);
    check("held_in_reset", 32'(dut_all), 32'(0));
    arst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step(1);
      check("post_reset_quiet", 32'({bus.level_o, bus.rise_o}), 32'(0));
    end
    step(1);
    check("post_reset_rise", 32'({bus.level_o, bus.rise_o}), 32'({3'b101, 3'b101}));
    step(1);
    check("post_reset_pend", 32'({bus.rise_o, bus.pending_o}), 32'({3'b000, 3'b101}));

    // Randomized run against the reference model
    arst = 1'b1; model_reset(); step(1); arst = 1'b0;
    r = AL; e = '0;
    for (int k = 0; k < 400; k++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(4) == 0) r[b] = ~r[b];
      c = '0;
      for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) c[b] = 1'b1;
      if (k % 16 == 0) e = 3'($urandom_range(7));
      bus.in_raw = r; bus.clr = c; bus.en_mask = e;
      model_edge(r, c);
      step(1);
      check($sformatf("rand%0d", k), 32'(dut_all),
            32'({m_level, m_rise, m_fall, m_pend, |(m_pend & e)}));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
